// File: rtl/csr_gpio_pkg.sv
// csr_gpio_pkg: shared constants, state type and BCD helper for the CSR GPIO responder.
package csr_gpio_pkg;

  localparam logic [11:0] CSR_IO0_ADDR = 12'hF00;
  localparam logic [11:0] CSR_IO2_ADDR = 12'hF02;

  typedef enum logic [1:0] {IDLE, CONV, DONE} gpio_state_t;

  localparam int BCD_DIGITS  = 10;
  localparam int CONV_CYCLES = 32;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Double-dabble correction step: every BCD nibble of 5 or more gets 3 added
  // so that the following left shift carries correctly into the next decade.
  function automatic logic [4*BCD_DIGITS-1:0] bcd_add3(input logic [4*BCD_DIGITS-1:0] bcd);
    logic [4*BCD_DIGITS-1:0] adj;
    adj = bcd;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
    end
    return adj;
  endfunction

endpackage

// File: rtl/csr_gpio_io_hex7seg.sv
// hex7seg: 4-bit value to active-low seven-segment pattern (bit 0 = segment a).
// Covers 0-9 for decimal display and A,b,C,d,E,F for raw hex display.
module hex7seg
  import csr_gpio_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  // Segment lookup; a dark digit is the fallback if the table is ever incomplete.
  always_comb begin
    o_seg = SEG_BLANK;
    case (i_nibble)
      4'h0: o_seg = 7'b1000000;
      4'h1: o_seg = 7'b1111001;
      4'h2: o_seg = 7'b0100100;
      4'h3: o_seg = 7'b0110000;
      4'h4: o_seg = 7'b0011001;
      4'h5: o_seg = 7'b0010010;
      4'h6: o_seg = 7'b0000010;
      4'h7: o_seg = 7'b1111000;
      4'h8: o_seg = 7'b0000000;
      4'h9: o_seg = 7'b0010000;
      4'hA: o_seg = 7'b0001000;
      4'hB: o_seg = 7'b0000011;
      4'hC: o_seg = 7'b1000110;
      4'hD: o_seg = 7'b0100001;
      4'hE: o_seg = 7'b0000110;
      4'hF: o_seg = 7'b0001110;
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/csr_gpio_io.sv
// csr_gpio_io: CSR-mapped switch/display responder for the 3-stage core.
// CSR 0xF00 reads the synchronized switches, CSR 0xF02 holds a display value that
// is shown in decimal on active-low seven-segment digits.
// Build option GPIO_HEX_MODE_EN: show io2 as raw hex nibbles instead, with no
// converter (busy tied low, display follows one edge after the write).
module csr_gpio_io
  import csr_gpio_pkg::*;
#(
  parameter int SW_WIDTH    = 18,
  parameter int NUM_DIGITS  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    csr_we,
  input  logic [11:0]             csr_addr,
  input  logic [31:0]             csr_wdata,
  output logic [31:0]             csr_rdata,
  input  logic [SW_WIDTH-1:0]     sw_in,
  output logic [7*NUM_DIGITS-1:0] hex_out,
  output logic                    busy
);

  logic [SW_WIDTH-1:0] r_sync [SYNC_STAGES];
  logic [31:0]         r_io2;
  logic [3:0]          r_digit [NUM_DIGITS];
  logic                w_io2_wr;

  assign w_io2_wr = csr_we && (csr_addr == CSR_IO2_ADDR);

  // Switch synchronizer chain; the last stage is what software sees.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
    end else begin
      r_sync[0] <= sw_in;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  // Combinational read port; during a csrrw this returns the value before the write.
  always_comb begin
    csr_rdata = '0;
    case (csr_addr)
      CSR_IO0_ADDR: csr_rdata = 32'(r_sync[SYNC_STAGES-1]);
      CSR_IO2_ADDR: csr_rdata = r_io2;
      default:      csr_rdata = '0;
    endcase
  end

  // io2 holding register, written only through CSR 0xF02.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_io2 <= '0;
    else if (w_io2_wr) r_io2 <= csr_wdata;
  end

`ifdef GPIO_HEX_MODE_EN

  assign busy = 1'b0;

  // Hex mode: digits take the raw nibbles of the written value on the write edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_DIGITS; k++) r_digit[k] <= '0;
    end else if (w_io2_wr) begin
      for (int k = 0; k < NUM_DIGITS; k++) r_digit[k] <= csr_wdata[4*k +: 4];
    end
  end

`else

  logic [4*BCD_DIGITS-1:0] r_bcd;
  logic [31:0]             r_bin;
  logic [5:0]              r_count;
  gpio_state_t             r_state;
  logic                    r_busy;
  logic [4*BCD_DIGITS-1:0] w_bcd_adj;

  assign w_bcd_adj = bcd_add3(r_bcd);
  assign busy      = r_busy;

  // Double-dabble FSM; a new write always restarts it, and only a finished
  // conversion reaches the digit registers, so abandoned values never show.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bcd   <= '0;
      r_bin   <= '0;
      r_count <= '0;
      r_state <= IDLE;
      r_busy  <= 1'b0;
      for (int k = 0; k < NUM_DIGITS; k++) r_digit[k] <= '0;
    end else if (w_io2_wr) begin
      r_bcd   <= '0;
      r_bin   <= csr_wdata;
      r_count <= '0;
      r_state <= CONV;
      r_busy  <= 1'b1;
    end else begin
      case (r_state)
        CONV: begin
          {r_bcd, r_bin} <= {w_bcd_adj[4*BCD_DIGITS-2:0], r_bin, 1'b0};
          r_count        <= r_count + 6'd1;
          if (r_count == 6'(CONV_CYCLES - 1)) r_state <= DONE;
        end
        DONE: begin
          for (int k = 0; k < NUM_DIGITS; k++) r_digit[k] <= r_bcd[4*k +: 4];
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

`endif

  // One decoder per digit; digit 0 sits in the lowest seven bits.
  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_seg
    hex7seg u_seg (
      .i_nibble (r_digit[k]),
      .o_seg    (hex_out[7*k +: 7])
    );
  end

endmodule

// File: tb/tb_csr_gpio_io.sv
// tb_csr_gpio_io: scoreboard bench for csr_gpio_io in its default decimal build.
// Each io2 write pushes the expected display; the entry is popped and compared
// when the conversion finishes, and dropped if a newer write replaces it.
module tb_csr_gpio_io;

  localparam int SW_WIDTH    = 18;
  localparam int NUM_DIGITS  = 8;
  localparam int SYNC_STAGES = 2;
  localparam int CONV_EDGES  = 33;

  logic                    clk = 1'b0;
  logic                    rst = 1'b0;
  logic                    csr_we = 1'b0;
  logic [11:0]             csr_addr = '0;
  logic [31:0]             csr_wdata = '0;
  logic [31:0]             csr_rdata;
  logic [SW_WIDTH-1:0]     sw_in = '0;
  logic [7*NUM_DIGITS-1:0] hex_out;
  logic                    busy;

  int nTests = 0;
  int nFail  = 0;

  logic [7*NUM_DIGITS-1:0] expQ[$];
  logic [7*NUM_DIGITS-1:0] shownHex;
  logic [31:0]             io2Model;

  csr_gpio_io #(
    .SW_WIDTH    (SW_WIDTH),
    .NUM_DIGITS  (NUM_DIGITS),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .csr_we    (csr_we),
    .csr_addr  (csr_addr),
    .csr_wdata (csr_wdata),
    .csr_rdata (csr_rdata),
    .sw_in     (sw_in),
    .hex_out   (hex_out),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Bounded run time so a stuck design still ends the simulation.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached (got timeout, required completion)");
    $fatal(1, "[TB] timeout");
  end

  function automatic logic [6:0] segOf(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // Expected display: low NUM_DIGITS decimal digits of the value, no blanking.
  function automatic logic [7*NUM_DIGITS-1:0] expHex(input logic [31:0] val);
    logic [7*NUM_DIGITS-1:0] r;
    longint unsigned v;
    v = 64'(val);
    for (int k = 0; k < NUM_DIGITS; k++) begin
      r[7*k +: 7] = segOf(int'(v % 10));
      v = v / 10;
    end
    return r;
  endfunction

  // Combinational CSR read at the current sample point.
  task automatic readCsr(input logic [11:0] addr, output logic [31:0] data);
    csr_addr = addr;
    #1;
    data = csr_rdata;
  endtask

  // One-cycle csrrw: returns the read data seen during the write cycle and
  // updates the scoreboard when the write targets io2.
  task automatic writeCsr(input logic [11:0] addr, input logic [31:0] data,
                          output logic [31:0] preRead);
    csr_we    = 1'b1;
    csr_addr  = addr;
    csr_wdata = data;
    #1;
    preRead = csr_rdata;
    @(negedge clk);
    csr_we = 1'b0;
    if (addr == 12'hF02) begin
      if (expQ.size() > 0) void'(expQ.pop_back());
      expQ.push_back(expHex(data));
      io2Model = data;
    end
  endtask

  // Counts samples with busy high and any display change while busy.
  task automatic waitConversion(output int busyCycles, output int glitches);
    busyCycles = 0;
    glitches   = 0;
    while (busy === 1'b1 && busyCycles < 100) begin
      if (hex_out !== shownHex) glitches++;
      @(negedge clk);
      busyCycles++;
    end
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    #3;
    rst = 1'b1;
    #1;
    nTests++;
    if (hex_out !== expHex(32'd0)) begin
      nFail++;
      $display("[TB] FAIL reset_hex: got %h required %h", hex_out, expHex(32'd0));
    end
    nTests++;
    if (busy !== 1'b0) begin
      nFail++;
      $display("[TB] FAIL reset_busy: got %b required 0", busy);
    end
    readCsr(12'hF02, rd);
    nTests++;
    if (rd !== 32'd0) begin
      nFail++;
      $display("[TB] FAIL reset_io2: got %h required 0", rd);
    end
    io2Model = '0;
    shownHex = expHex(32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Full conversion of a value: pre-write read, read-back, latency, no glitch, display.
  task automatic test_convert(input string name, input logic [31:0] val);
    logic [31:0] pre, rd;
    logic [31:0] oldIo2;
    logic [7*NUM_DIGITS-1:0] expVal;
    int busyCycles, glitches;
    oldIo2 = io2Model;
    writeCsr(12'hF02, val, pre);
    nTests++;
    if (pre !== oldIo2) begin
      nFail++;
      $display("[TB] FAIL %s_prewrite_read: got %h required %h", name, pre, oldIo2);
    end
    readCsr(12'hF02, rd);
    nTests++;
    if (rd !== val) begin
      nFail++;
      $display("[TB] FAIL %s_io2_read: got %h required %h", name, rd, val);
    end
    waitConversion(busyCycles, glitches);
    nTests++;
    if (busyCycles != CONV_EDGES) begin
      nFail++;
      $display("[TB] FAIL %s_busy_edges: got %0d required %0d", name, busyCycles, CONV_EDGES);
    end
    nTests++;
    if (glitches != 0) begin
      nFail++;
      $display("[TB] FAIL %s_early_display: got %0d changes required 0", name, glitches);
    end
    expVal = (expQ.size() > 0) ? expQ.pop_front() : 'x;
    nTests++;
    if (hex_out !== expVal) begin
      nFail++;
      $display("[TB] FAIL %s_display: got %h required %h", name, hex_out, expVal);
    end
    shownHex = expVal;
  endtask

  task automatic test_switches();
    logic [31:0] rd;
    sw_in = 18'h2A5A5;
    readCsr(12'hF00, rd);
    nTests++;
    if (rd !== 32'd0) begin
      nFail++;
      $display("[TB] FAIL sw_edge0: got %h required 0", rd);
    end
    @(negedge clk);
    readCsr(12'hF00, rd);
    nTests++;
    if (rd !== 32'd0) begin
      nFail++;
      $display("[TB] FAIL sw_edge1: got %h required 0", rd);
    end
    @(negedge clk);
    readCsr(12'hF00, rd);
    nTests++;
    if (rd !== 32'h0002A5A5) begin
      nFail++;
      $display("[TB] FAIL sw_edge2: got %h required 0002a5a5", rd);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] pre;
    logic [7*NUM_DIGITS-1:0] expVal;
    int busyLow, glitches, busyCycles, g2;
    busyLow  = 0;
    glitches = 0;
    writeCsr(12'hF02, 32'd1234, pre);
    for (int i = 0; i < 9; i++) begin
      if (busy !== 1'b1) busyLow++;
      if (hex_out !== shownHex) glitches++;
      @(negedge clk);
    end
    writeCsr(12'hF02, 32'd99, pre);
    nTests++;
    if (pre !== 32'd1234) begin
      nFail++;
      $display("[TB] FAIL b2b_prewrite_read: got %h required %h", pre, 32'd1234);
    end
    waitConversion(busyCycles, g2);
    glitches += g2;
    nTests++;
    if (busyLow != 0) begin
      nFail++;
      $display("[TB] FAIL b2b_busy_gap: got %0d idle samples required 0", busyLow);
    end
    nTests++;
    if (busyCycles != CONV_EDGES) begin
      nFail++;
      $display("[TB] FAIL b2b_busy_edges: got %0d required %0d", busyCycles, CONV_EDGES);
    end
    nTests++;
    if (glitches != 0) begin
      nFail++;
      $display("[TB] FAIL b2b_abandoned_shown: got %0d changes required 0", glitches);
    end
    expVal = (expQ.size() > 0) ? expQ.pop_front() : 'x;
    nTests++;
    if (hex_out !== expVal) begin
      nFail++;
      $display("[TB] FAIL b2b_display: got %h required %h", hex_out, expVal);
    end
    shownHex = expVal;
  endtask

  task automatic test_ignored_writes();
    logic [31:0] pre, rd;
    writeCsr(12'hF00, 32'd5, pre);
    writeCsr(12'h123, 32'd7, pre);
    nTests++;
    if (pre !== 32'd0) begin
      nFail++;
      $display("[TB] FAIL ign_prewrite_read: got %h required 0", pre);
    end
    @(negedge clk);
    nTests++;
    if (busy !== 1'b0) begin
      nFail++;
      $display("[TB] FAIL ign_busy: got %b required 0", busy);
    end
    nTests++;
    if (hex_out !== shownHex) begin
      nFail++;
      $display("[TB] FAIL ign_display: got %h required %h", hex_out, shownHex);
    end
    readCsr(12'h123, rd);
    nTests++;
    if (rd !== 32'd0) begin
      nFail++;
      $display("[TB] FAIL ign_read_other: got %h required 0", rd);
    end
    readCsr(12'hF02, rd);
    nTests++;
    if (rd !== io2Model) begin
      nFail++;
      $display("[TB] FAIL ign_io2_kept: got %h required %h", rd, io2Model);
    end
  endtask

  task automatic test_reset_mid_conv();
    logic [31:0] pre, rd;
    writeCsr(12'hF02, 32'd500, pre);
    repeat (10) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    expQ.delete();
    io2Model = '0;
    shownHex = expHex(32'd0);
    nTests++;
    if (busy !== 1'b0) begin
      nFail++;
      $display("[TB] FAIL rstmid_busy: got %b required 0", busy);
    end
    nTests++;
    if (hex_out !== shownHex) begin
      nFail++;
      $display("[TB] FAIL rstmid_display: got %h required %h", hex_out, shownHex);
    end
    readCsr(12'hF02, rd);
    nTests++;
    if (rd !== 32'd0) begin
      nFail++;
      $display("[TB] FAIL rstmid_io2: got %h required 0", rd);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    nTests++;
    if (busy !== 1'b0 || hex_out !== shownHex) begin
      nFail++;
      $display("[TB] FAIL rstmid_after: got busy=%b hex=%h required busy=0 hex=%h",
               busy, hex_out, shownHex);
    end
  endtask

  initial begin
    $display("[TB] starting csr_gpio_io bench");
    test_reset();
    test_convert("dec12345678", 32'd12345678);
    test_convert("overflow_max", 32'hFFFFFFFF);
    test_switches();
    test_back_to_back();
    test_ignored_writes();
    test_convert("pow10_8", 32'd100000000);
    test_convert("nines", 32'd99999999);
    test_convert("zero", 32'd0);
    for (int i = 0; i < 3; i++) begin
      test_convert($sformatf("rand%0d", i), $urandom);
    end
    test_reset_mid_conv();
    test_convert("after_reset", 32'd7);
    nTests++;
    if (expQ.size() != 0) begin
      nFail++;
      $display("[TB] FAIL scoreboard_drain: got %0d entries required 0", expQ.size());
    end
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule

// File: doc/csr_gpio_io.md
Name: csr_gpio_io

Overview:
CSR-mapped I/O responder for the 3-stage RISC-V core. It serves csrrw from the EX stage: reads synchronized board switches at CSR 0xF00 (io0) and holds the value written to CSR 0xF02 (io2). It converts the io2 value to decimal with an iterative double-dabble engine and drives active-low seven-segment displays. It sits beside the register file and takes GPIO_we, imm12 and rs1 data from the control/EX path.

Parameters:
SW_WIDTH, 18, switch input width; zero-extended to 32 on read.
NUM_DIGITS, 8, seven-segment digits driven; legal range 1..10.
SYNC_STAGES, 2, switch synchronizer depth; minimum 2.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-high reset.
csr_we  input  1  write strobe; driven by the control unit's GPIO_we.
csr_addr  input  12  CSR address (instruction imm12).
csr_wdata  input  32  write data (rs1 value).
csr_rdata  output  32  read data for the csrrw destination register.
sw_in  input  SW_WIDTH  raw asynchronous board switches.
hex_out  output  7*NUM_DIGITS  segments; digit k is bits [7k+6:7k]; active-low; digit 0 is least significant.
busy  output  1  high while a conversion is pending.

Behaviour:
- Reset (asynchronous, immediate): io2_q=0, all sync flops=0, BCD shift register=0, iteration count=0, state=IDLE, all digit registers=0.
  - Resulting outputs: busy=0; every hex_out digit=7'b1000000 ("0").
- Reads are combinational, with no read strobe:
  - 0xF00 -> {zero-pad, sw_sync}.
  - 0xF02 -> io2_q.
  - Any other address -> 0.
  - csrrw returns the pre-write value; a write lands on the edge that ends the cycle.
- Switch path: SYNC_STAGES-flop synchronizer. An sw_in change appears on reads after SYNC_STAGES edges.
- Write: csr_we=1 and csr_addr=0xF02 on an edge does both of the following:
  - io2_q <= csr_wdata.
  - Converter loads {BCD=0, bin=csr_wdata}, count=0, state=CONV.
- Writes to 0xF00 or any other address are ignored. No state changes.
- FSM:
  - IDLE: waits for a write.
  - CONV: each edge adds 3 to every BCD nibble >=5, then shifts {bcd,bin} left by 1 and increments count. After the 32nd shift, next state is DONE.
  - DONE: one edge copies the low NUM_DIGITS BCD nibbles (of 10) into the digit registers, then returns to IDLE.
- Latency: the display updates on the 33rd edge after the write edge. busy=1 during CONV and DONE, registered from state.
- Write while busy: io2_q updates and the conversion restarts from the new value. The digit registers keep the last completed value, and an abandoned conversion is never displayed.
- Overflow: values >= 10^NUM_DIGITS display modulo 10^NUM_DIGITS. There is no leading-zero blanking.
- Reset mid-conversion: aborts the conversion and takes the reset values above.

Optional Feature:
GPIO_HEX_MODE_EN:
- Defined: the converter and FSM are compiled out and busy is tied 0. The digit registers load the raw nibbles io2_q[4k+3:4k] on the write edge, so the display updates 1 edge after the write. NUM_DIGITS is limited to 8, and nibbles A-F show as A,b,C,d,E,F.
- Undefined: decimal behaviour as above.

Decomposition:
- Package csr_gpio_pkg holds:
  - CSR_IO0_ADDR=12'hF00 and CSR_IO2_ADDR=12'hF02.
  - Typedef enum logic [1:0] {IDLE, CONV, DONE} gpio_state_t.
  - BCD_DIGITS=10 and CONV_CYCLES=32.
  - SEG_BLANK=7'h7F.
- Sub-module hex7seg: combinational 4-bit to active-low 7-segment, instantiated NUM_DIGITS times via generate. It is shared with hex mode.

Test Plan:
1. Reset: assert rst mid-cycle -> hex_out all 7'b1000000 immediately; busy=0; read 0xF02 -> 0.
2. Write 0xF02=32'd12345678 -> busy high for exactly 33 edges; read 0xF02 -> 12345678 the next cycle; digits 7..0 show 1,2,3,4,5,6,7,8.
3. Write 0xF02=32'hFFFFFFFF -> display 94967295 after 33 edges; read 0xF02 -> 32'hFFFFFFFF.
4. sw_in=18'h2A5A5 -> read 0xF00 returns 0 for the first edge, then 32'h0002A5A5 after 2 edges.
5. Write 1234, then write 99 ten edges later -> display never shows 1234; shows 00000099 33 edges after the second write; busy continuous.
6. Write 0xF00=5 and 0x123=7 -> no state change; read 0x123 -> 0. Then write 500 and assert rst at edge 10 of the conversion -> busy=0, display zeros, io2_q=0.
